// File: rtl/branch_seq_pkg.sv
// Shared definitions for the branch fetch/execute sequencer.
//   state_e   : sequencer state encoding (IDLE, T0..T6, ERR)
//   cond_e    : two-bit branch condition codes from the instruction
//   CTRL_W    : width of the control strobe bundle
//   Ctrl*     : bit positions of each strobe inside ctrl
//   cond_eval : resolves a condition code against bus-value properties
package branch_seq_pkg;

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StT0   = 4'd1,
        StT1   = 4'd2,
        StT2   = 4'd3,
        StT3   = 4'd4,
        StT4   = 4'd5,
        StT5   = 4'd6,
        StT6   = 4'd7,
        StErr  = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        CondZr = 2'b00,  // branch if zero
        CondNz = 2'b01,  // branch if non-zero
        CondPl = 2'b10,  // branch if positive (sign clear)
        CondMi = 2'b11   // branch if negative (sign set)
    } cond_e;

    localparam int unsigned CTRL_W = 15;

    localparam int unsigned CtrlPcOut   = 0;
    localparam int unsigned CtrlMarIn   = 1;
    localparam int unsigned CtrlIncPc   = 2;
    localparam int unsigned CtrlPcIn    = 3;
    localparam int unsigned CtrlZIn     = 4;
    localparam int unsigned CtrlZlowOut = 5;
    localparam int unsigned CtrlRamRead = 6;
    localparam int unsigned CtrlMdrIn   = 7;
    localparam int unsigned CtrlMdrOut  = 8;
    localparam int unsigned CtrlIrIn    = 9;
    localparam int unsigned CtrlGra     = 10;
    localparam int unsigned CtrlROut    = 11;
    localparam int unsigned CtrlConIn   = 12;
    localparam int unsigned CtrlYIn     = 13;
    localparam int unsigned CtrlCOut    = 14;

    function automatic logic cond_eval(input cond_e cond, input logic is_zero,
                                       input logic sign);
        logic res;
        unique case (cond)
            CondZr:  res = is_zero;
            CondNz:  res = ~is_zero;
            CondPl:  res = ~sign;
            CondMi:  res = sign;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/con_ff_logic.sv
// Branch condition evaluator and condition flag register.
//   clock    : rising-edge clock
//   clear    : asynchronous active-low reset, clears the flag
//   con_in_i : load strobe; flag captures the evaluated condition
//   cond_i   : condition code field from the instruction
//   bus_i    : register value under test
//   con_o    : registered condition flag, held while con_in_i is low
module con_ff_logic
    import branch_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              con_in_i,
    input  logic [1:0]        cond_i,
    input  logic [DATA_W-1:0] bus_i,
    output logic              con_o
);

    logic con_q;
    logic con_d;
    logic cond_true;

    always_comb begin
        cond_true = cond_eval(cond_e'(cond_i), (bus_i == '0), bus_i[DATA_W-1]);
        con_d     = con_in_i ? cond_true : con_q;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            con_q <= 1'b0;
        end else begin
            con_q <= con_d;
        end
    end

    assign con_o = con_q;

endmodule

// File: rtl/branch_sequencer.sv
// Control sequencer for one instruction fetch followed by a conditional branch.
//   clock     : rising-edge clock
//   clear     : asynchronous active-low reset
//   start     : begin a sequence (only honoured in IDLE or at the end of T6)
//   mem_ready : memory read data valid, sampled while in T1
//   ir        : instruction register contents (opcode and condition fields)
//   bus_in    : register value evaluated by the branch condition in T3
//   ctrl      : datapath strobe bundle, decoded from the registered state
//   con       : registered branch-condition flag
//   busy      : high in every state but IDLE
//   done      : one-cycle pulse in T6
//   illegal   : one-cycle pulse in T3 when the opcode is not a branch
//   timeout   : sticky flag, set when the memory wait limit is reached
module branch_sequencer
    import branch_seq_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       OPC_W     = 5,
    parameter logic [OPC_W-1:0]  BR_OPCODE = 5'b00100,
    parameter int unsigned       COND_LSB  = 19,
    parameter int unsigned       WAIT_MAX  = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] ir,
    input  logic [DATA_W-1:0] bus_in,
    output logic [CTRL_W-1:0] ctrl,
    output logic              con,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              timeout
);

    localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;

    logic [OPC_W-1:0] opcode;
    logic [1:0]       cond_field;
    logic             is_branch;
    logic [CntW-1:0]  wait_cnt_inc;

    assign opcode       = ir[DATA_W-1 -: OPC_W];
    assign cond_field   = ir[COND_LSB+1:COND_LSB];
    assign is_branch    = (opcode == BR_OPCODE);
    assign wait_cnt_inc = wait_cnt_q + CntW'(1);

    // Only the opcode and condition fields matter here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        ctrl       = '0;
        done       = 1'b0;
        illegal    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StT0;
                end
            end
            StT0: begin
                ctrl[CtrlPcOut] = 1'b1;
                ctrl[CtrlMarIn] = 1'b1;
                ctrl[CtrlIncPc] = 1'b1;
                ctrl[CtrlZIn]   = 1'b1;
                wait_cnt_d      = '0;
                state_d         = StT1;
            end
            StT1: begin
                ctrl[CtrlZlowOut] = 1'b1;
                ctrl[CtrlRamRead] = 1'b1;
                ctrl[CtrlMdrIn]   = 1'b1;
                // The counter is still zero only in the first T1 cycle, so the
                // incremented PC is written back exactly once per fetch.
                ctrl[CtrlPcIn]    = (wait_cnt_q == '0);
                if (mem_ready) begin
                    wait_cnt_d = '0;
                    state_d    = StT2;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == CntW'(WAIT_MAX)) begin
                        timeout_d = 1'b1;
                        state_d   = StErr;
                    end
                end
            end
            StT2: begin
                ctrl[CtrlMdrOut] = 1'b1;
                ctrl[CtrlIrIn]   = 1'b1;
                state_d          = StT3;
            end
            StT3: begin
                if (is_branch) begin
                    ctrl[CtrlGra]   = 1'b1;
                    ctrl[CtrlROut]  = 1'b1;
                    ctrl[CtrlConIn] = 1'b1;
                    state_d         = StT4;
                end else begin
                    illegal = 1'b1;
                    state_d = StIdle;
                end
            end
            StT4: begin
                ctrl[CtrlPcOut] = 1'b1;
                ctrl[CtrlYIn]   = 1'b1;
                state_d         = StT5;
            end
            StT5: begin
                ctrl[CtrlCOut] = 1'b1;
                ctrl[CtrlZIn]  = 1'b1;
                state_d        = StT6;
            end
            StT6: begin
                ctrl[CtrlZlowOut] = 1'b1;
                // Not-taken branch leaves PC at the value written in T1.
                ctrl[CtrlPcIn]    = con;
                done              = 1'b1;
                state_d           = start ? StT0 : StIdle;
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign timeout = timeout_q;

    con_ff_logic #(
        .DATA_W (DATA_W)
    ) u_con_ff_logic (
        .clock    (clock),
        .clear    (clear),
        .con_in_i (ctrl[CtrlConIn]),
        .cond_i   (cond_field),
        .bus_i    (bus_in),
        .con_o    (con)
    );

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed vector table, hand-written
// corner sequences (timeout, async reset mid-sequence, back-to-back) and
// randomized transactions checked cycle by cycle against a sequence model.
module tb_branch_sequencer;
    import branch_seq_pkg::*;

    localparam int WAIT_MAX = 15;

    logic              clock = 1'b0;
    logic              clear;
    logic              start;
    logic              mem_ready;
    logic [31:0]       ir;
    logic [31:0]       bus_in;
    logic [CTRL_W-1:0] ctrl;
    logic              con, busy, done, illegal, timeout;

    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    logic con_m = 1'b0;

    logic [CTRL_W-1:0] m_t0, m_t1, m_t2, m_t3, m_t4, m_t5, m_t6, m_pcin;

    always #5 clock = ~clock;

    branch_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .mem_ready (mem_ready),
        .ir        (ir),
        .bus_in    (bus_in),
        .ctrl      (ctrl),
        .con       (con),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .timeout   (timeout)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    function automatic logic [CTRL_W-1:0] bit_of(input int unsigned i);
        logic [CTRL_W-1:0] m;
        m    = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    // Reference rules: opcode is the top five bits, condition is ir[20:19].
    function automatic logic is_branch_m(input logic [31:0] ir_v);
        logic [4:0] opc;
        opc = ir_v[31:27];
        return opc == 5'b00100;
    endfunction

    function automatic logic cond_m(input logic [31:0] ir_v, input logic [31:0] b);
        logic [1:0] c;
        c = ir_v[20:19];
        if (c == 2'd0) return b == 32'd0;
        if (c == 2'd1) return b != 32'd0;
        if (c == 2'd2) return b[31] == 1'b0;
        return b[31] == 1'b1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // flags = {busy, done, illegal, timeout}
    task automatic chk_cyc(input string name, input logic [CTRL_W-1:0] ec,
                           input logic [3:0] ef);
        chk({name, "_ctrl"}, 64'(ctrl), 64'(ec));
        chk({name, "_flags"}, 64'({busy, done, illegal, timeout}), 64'(ef));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        #2;
        clear = 1'b0;
        #1;
        chk("rst_ctrl", 64'(ctrl), 64'd0);
        chk("rst_flags", 64'({busy, done, illegal, timeout, con}), 64'd0);
        @(posedge clock);
        #1;
        clear     = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b0;
        con_m     = 1'b0;
    endtask

    // Runs one fetch/branch sequence. Entered #1 after an edge, either in IDLE
    // (from_idle) or already in T0 (chained from a previous T6).
    task automatic run_txn(input logic [31:0] ir_v, input logic [31:0] bus_v, input int w,
                           input bit from_idle, input bit next_start, input bit noise,
                           output int done_cyc, output bit err, output bit ill);
        done_cyc = -1;
        err      = 1'b0;
        ill      = 1'b0;
        ir       = ir_v;
        bus_in   = bus_v;
        if (from_idle) begin
            chk_cyc("idle", '0, 4'b0000);
            start     = 1'b1;
            mem_ready = 1'($urandom % 2);
            cyc       = 0;
            tick();
        end
        start = noise ? 1'($urandom % 2) : 1'b0;
        chk_cyc("t0", m_t0, 4'b1000);
        tick();
        for (int i = 0; i <= w && i < WAIT_MAX; i++) begin
            mem_ready = (i == w);
            chk_cyc("t1", (i == 0) ? (m_t1 | m_pcin) : m_t1, 4'b1000);
            if (noise) start = 1'($urandom % 2);
            tick();
        end
        if (w >= WAIT_MAX) begin
            for (int k = 0; k < 3; k++) begin
                start = 1'b1;
                chk_cyc("err", '0, 4'b1001);
                chk("err_con", 64'(con), 64'(con_m));
                tick();
            end
            start = 1'b0;
            err   = 1'b1;
            return;
        end
        chk_cyc("t2", m_t2, 4'b1000);
        tick();
        chk("t3_con_hold", 64'(con), 64'(con_m));
        if (!is_branch_m(ir_v)) begin
            chk_cyc("t3_illegal", '0, 4'b1010);
            start = 1'b0;
            tick();
            ill = 1'b1;
            return;
        end
        chk_cyc("t3", m_t3, 4'b1000);
        tick();
        con_m = cond_m(ir_v, bus_v);
        chk_cyc("t4", m_t4, 4'b1000);
        chk("t4_con", 64'(con), 64'(con_m));
        tick();
        chk_cyc("t5", m_t5, 4'b1000);
        chk("t5_con", 64'(con), 64'(con_m));
        tick();
        chk_cyc("t6", con_m ? (m_t6 | m_pcin) : m_t6, 4'b1100);
        done_cyc = cyc;
        start    = next_start;
        if (next_start) cyc = 0;
        tick();
        if (!next_start) chk("post_con_hold", 64'(con), 64'(con_m));
    endtask

    typedef struct {
        logic [31:0] ir_v;
        logic [31:0] bus_v;
        int          w;
        logic        exp_con;
        int          exp_done;
        bit          exp_ill;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int          dc;
        bit          e, il, nxt, from_idle;
        logic [31:0] ir_v, bus_v;
        int          w;

        m_pcin = bit_of(CtrlPcIn);
        m_t0   = bit_of(CtrlPcOut) | bit_of(CtrlMarIn) | bit_of(CtrlIncPc) | bit_of(CtrlZIn);
        m_t1   = bit_of(CtrlZlowOut) | bit_of(CtrlRamRead) | bit_of(CtrlMdrIn);
        m_t2   = bit_of(CtrlMdrOut) | bit_of(CtrlIrIn);
        m_t3   = bit_of(CtrlGra) | bit_of(CtrlROut) | bit_of(CtrlConIn);
        m_t4   = bit_of(CtrlPcOut) | bit_of(CtrlYIn);
        m_t5   = bit_of(CtrlCOut) | bit_of(CtrlZIn);
        m_t6   = bit_of(CtrlZlowOut);

        tbl[0] = '{32'h2098001B, 32'hFFFFFFEC, 0,  1'b1, 7,  1'b0};  // brmi taken
        tbl[1] = '{32'h2080001B, 32'hFFFFFFEC, 0,  1'b0, 7,  1'b0};  // brzr not taken
        tbl[2] = '{32'h2080001B, 32'h00000000, 0,  1'b1, 7,  1'b0};  // brzr taken
        tbl[3] = '{32'h2088001B, 32'h00000014, 0,  1'b1, 7,  1'b0};  // brnz taken
        tbl[4] = '{32'h2090001B, 32'h00000014, 0,  1'b1, 7,  1'b0};  // brpl taken
        tbl[5] = '{32'h2098001B, 32'h00000014, 0,  1'b0, 7,  1'b0};  // brmi not taken
        tbl[6] = '{32'h2098001B, 32'hFFFFFFEC, 3,  1'b1, 10, 1'b0};  // three wait cycles
        tbl[7] = '{32'h2090001B, 32'h80000000, 14, 1'b0, 21, 1'b0};  // one short of timeout
        tbl[8] = '{32'h1898001B, 32'hFFFFFFEC, 0,  1'b0, -1, 1'b1};  // opcode 00011

        clear     = 1'b0;
        start     = 1'b0;
        mem_ready = 1'b0;
        ir        = '0;
        bus_in    = '0;
        #1;
        chk("init_ctrl", 64'(ctrl), 64'd0);
        chk("init_flags", 64'({busy, done, illegal, timeout, con}), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;

        foreach (tbl[i]) begin
            run_txn(tbl[i].ir_v, tbl[i].bus_v, tbl[i].w, 1'b1, 1'b0, 1'b0, dc, e, il);
            chk("tbl_con", 64'(con), 64'(tbl[i].exp_con));
            chk("tbl_done_cycle", 64'(dc), 64'(tbl[i].exp_done));
            chk("tbl_illegal", 64'(il), 64'(tbl[i].exp_ill));
        end
        chk_cyc("after_illegal_idle", '0, 4'b0000);

        // Memory never ready: ERR after the wait limit, sticky until reset.
        run_txn(32'h2098001B, 32'hFFFFFFEC, WAIT_MAX, 1'b1, 1'b0, 1'b0, dc, e, il);
        chk("timeout_err", 64'(e), 64'd1);
        do_reset();
        chk_cyc("after_err_reset", '0, 4'b0000);

        // Asynchronous reset while in T4, then a clean restart.
        ir        = 32'h2098001B;
        bus_in    = 32'hFFFFFFEC;
        mem_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk_cyc("pre_rst_t4", m_t4, 4'b1000);
        chk("pre_rst_con", 64'(con), 64'd1);
        do_reset();
        chk_cyc("post_rst_idle", '0, 4'b0000);
        chk("post_rst_con", 64'(con), 64'd0);
        start = 1'b1;
        cyc   = 0;
        tick();
        chk("restart_con", 64'(con), 64'd0);
        run_txn(32'h2098001B, 32'hFFFFFFEC, 0, 1'b0, 1'b0, 1'b0, dc, e, il);
        chk("restart_done_cycle", 64'(dc), 64'd7);

        // Back-to-back: start held in T6 goes straight to T0.
        run_txn(32'h2098001B, 32'hFFFFFFEC, 0, 1'b1, 1'b1, 1'b0, dc, e, il);
        chk("b2b_first_done", 64'(dc), 64'd7);
        run_txn(32'h2088001B, 32'h00000000, 2, 1'b0, 1'b0, 1'b0, dc, e, il);
        chk("b2b_second_done", 64'(dc), 64'd9);
        chk("b2b_con", 64'(con), 64'd0);

        // Randomized transactions with start noise while busy.
        from_idle = 1'b1;
        for (int k = 0; k < 60; k++) begin
            ir_v = $urandom;
            if ($urandom % 8 != 0) ir_v[31:27] = 5'b00100;
            case ($urandom % 4)
                0:       bus_v = 32'd0;
                1:       bus_v = $urandom | 32'h80000000;
                2:       bus_v = $urandom & 32'h7FFFFFFF;
                default: bus_v = $urandom;
            endcase
            w   = ($urandom % 6 == 0) ? 14 : int'($urandom % 4);
            nxt = ($urandom % 3 == 0);
            run_txn(ir_v, bus_v, w, from_idle, nxt, 1'b1, dc, e, il);
            if (!il) chk("rand_done_cycle", 64'(dc), 64'(7 + w));
            from_idle = il || !nxt;
            if (from_idle && ($urandom % 2 == 1)) begin
                chk_cyc("rand_idle", '0, 4'b0000);
                tick();
            end
        end
        if (!from_idle) begin
            run_txn(32'h2090001B, 32'h00000001, 1, 1'b0, 1'b0, 1'b0, dc, e, il);
            chk("rand_tail_done", 64'(dc), 64'd8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter DATA_W, default 32: datapath/bus width.
REQ-002 Parameter OPC_W, default 5: opcode field width, located at ir[DATA_W-1 -: OPC_W].
REQ-003 Parameter BR_OPCODE, default 5'b00100: opcode value of the branch instruction.
REQ-004 Parameter COND_LSB, default 19: condition field is ir[COND_LSB+1:COND_LSB].
REQ-005 Parameter WAIT_MAX, default 15: maximum memory wait cycles before error.
REQ-006 clock  input  1  single clock; all state updates on its rising edge.
REQ-007 clear  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  request one fetch/branch-execute sequence; sampled only in IDLE.
REQ-009 mem_ready  input  1  memory read data valid; sampled in T1.
REQ-010 ir  input  DATA_W  current instruction register contents.
REQ-011 bus_in  input  DATA_W  bus value (R[ra]) sampled in T3.
REQ-012 ctrl  output  CTRL_W  one-hot-per-signal strobe bundle (bit map in package).
REQ-013 con  output  1  registered branch-condition flag.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse in T6.
REQ-016 illegal  output  1  one-cycle pulse on opcode mismatch.
REQ-017 timeout  output  1  sticky error flag, set on memory wait expiry.

Function
REQ-018 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6, ERR; one state per clock except T1 waits.
REQ-019 IDLE: all strobes low; go to T0 when start=1, otherwise stay.
REQ-020 T0: pc_out, mar_in, inc_pc, z_in asserted; next T1.
REQ-021 T1: zlow_out, pc_in, ram_read, mdr_in asserted; pc_in only in the first T1 cycle; stay while mem_ready=0; next T2 when mem_ready=1.
REQ-022 T1 wait counter SHALL count cycles with mem_ready=0; reaching WAIT_MAX -> ERR, timeout=1.
REQ-023 T2: mdr_out, ir_in asserted; next T3.
REQ-024 T3: if ir opcode != BR_OPCODE, no strobes, illegal=1, next IDLE; else gra, r_out, con_in asserted and con loads the condition result, next T4.
REQ-025 Condition codes: 00 brzr (bus_in==0), 01 brnz (bus_in!=0), 10 brpl (bus_in[DATA_W-1]==0), 11 brmi (bus_in[DATA_W-1]==1).
REQ-026 T4: pc_out, y_in asserted; next T5.
REQ-027 T5: c_out, z_in asserted; next T6.
REQ-028 T6: zlow_out asserted; pc_in asserted only if con=1; done=1; next T0 if start=1, else IDLE.
REQ-029 Not-taken branch SHALL leave PC at incremented value (no pc_in in T6).
REQ-030 Latency, start to done with mem_ready=1 in first T1: 7 cycles; each wait cycle adds one.
REQ-031 ERR: all strobes low, busy=1; leaves only via reset.
REQ-032 con SHALL hold its value outside T3; start while busy is ignored.

Reset
REQ-033 clear=0 SHALL immediately force IDLE, ctrl=0, con=0, done=0, illegal=0, timeout=0, wait counter=0, independent of clock.
REQ-034 Reset mid-sequence SHALL abort without completing pending strobes; first start after release begins at T0.

Structure
REQ-035 Package branch_seq_pkg holds state encoding, condition codes, CTRL_W and ctrl bit indices (pc_out, mar_in, inc_pc, pc_in, z_in, zlow_out, ram_read, mdr_in, mdr_out, ir_in, gra, r_out, con_in, y_in, c_out).
REQ-036 Condition evaluation SHALL be sub-module con_ff_logic (combinational compare plus con register).
REQ-037 ctrl SHALL be decoded from the registered state; no output depends combinationally on start.

Verification
REQ-038 ir=0x2098001B (brmi), bus_in=0xFFFFFFEC, mem_ready=1 -> con=1, pc_in in T6, done at cycle 7.
REQ-039 ir=0x2080001B (brzr), bus_in=0xFFFFFFEC -> con=0, no pc_in in T6; with bus_in=0 -> con=1.
REQ-040 ir=0x2088001B/0x2090001B with bus_in=0x14 -> brnz con=1, brpl con=1.
REQ-041 mem_ready low 3 cycles -> T1 held 4 cycles, done at cycle 10; held low 15 cycles -> ERR, timeout=1.
REQ-042 ir opcode 5'b00011 -> illegal pulse in T3, no gra/r_out, return to IDLE.
REQ-043 clear=0 asserted in T4 -> outputs zero asynchronously; start after release -> T0 with con=0.
